ddc_buf_rd_sched: RTL and testbench

- Read-side scheduler for the DDC capture RAM (32-bit {I,Q} words, circular, addresses 0..DEPTH-1) on the local-bus clock domain.
- Tracks the synchronised write pointer and waits until a full frame of FRAME_LEN samples is buffered.
- Drives the RAM read address, absorbs RAM read latency in a 4-entry output buffer, and emits frames on a valid/ready stream with last-flag.
- Detects writer lap-around (overrun) and resynchronises.

---
 rtl/ddc_buf_rd_sched.sv | 214 +++++++++++++++++++++
 tb/tb_ddc_buf_rd_sched.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddc_buf_rd_sched.sv
// Read-side scheduler for the circular DDC capture RAM: waits for a buffered frame, streams it out.
// Optional statistics counters (frame_cnt, ovr_cnt) are built when DDC_RD_STAT_EN is defined.
module ddc_buf_rd_sched #(
  parameter int U_DLY      = 1,
  parameter int DEPTH      = 11521,
  parameter int FRAME_LEN  = 256,
  parameter int RD_LAT     = 1,
  parameter int OVR_MARGIN = 64
) (
  input  logic        lbs_clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [13:0] wr_ptr,
  output logic [13:0] ram_addr,
  input  logic [31:0] ram_rdata,
  output logic        m_tvalid,
  input  logic        m_tready,
  output logic [31:0] m_tdata,
  output logic        m_tlast,
  output logic        busy,
  output logic        frame_done,
  output logic        ovr_flag,
  input  logic        ovr_clr,
  output logic [1:0]  dbg_state
`ifdef DDC_RD_STAT_EN
  ,
  output logic [15:0] frame_cnt,
  output logic [7:0]  ovr_cnt
`endif
);

  if (RD_LAT < 1 || RD_LAT > 3 || FRAME_LEN < 1 || FRAME_LEN > DEPTH - OVR_MARGIN - 1 || U_DLY < 0)
  begin : g_bad_param
    $error("ddc_buf_rd_sched: parameter out of range");
  end

  // Stream handshake: a beat transfers when m_tvalid & m_tready; tvalid/tdata/tlast hold until then.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_READ  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  localparam logic [14:0] DEPTH15   = 15'(DEPTH);
  localparam logic [14:0] OVR_TH    = 15'(DEPTH - OVR_MARGIN);
  localparam logic [14:0] FRAME15   = 15'(FRAME_LEN);
  localparam logic [13:0] LAST_ADDR = 14'(DEPTH - 1);

  state_t        state_q, state_d;
  logic [13:0]   rd_ptr_q, rd_ptr_d;
  logic [14:0]   fill_q, fill_d;
  logic [14:0]   cnt_q, cnt_d;
  logic [13:0]   ram_addr_q, ram_addr_d;
  logic [RD_LAT:0] tag_v_q, tag_v_d;
  logic [RD_LAT:0] tag_l_q, tag_l_d;
  logic [3:0]    bv_q, bv_d;
  logic [3:0]    bl_q, bl_d;
  logic [31:0]   bd_q [4];
  logic [31:0]   bd_d [4];
  logic          frame_done_q, frame_done_d;
  logic          ovr_flag_q, ovr_flag_d;
  logic          busy_q;
  logic          issue, last_issue, pop, capture, ovr_ev;
  logic [2:0]    occ, inflight, widx;
`ifdef DDC_RD_STAT_EN
  logic [15:0]   frame_cnt_q, frame_cnt_d;
  logic [7:0]    ovr_cnt_q, ovr_cnt_d;
`endif

  always_comb begin
    state_d      = state_q;
    rd_ptr_d     = rd_ptr_q;
    cnt_d        = cnt_q;
    ram_addr_d   = ram_addr_q;
    frame_done_d = 1'b0;
    ovr_ev       = 1'b0;
    issue        = 1'b0;
    occ          = 3'd0;
    inflight     = 3'd0;
    for (int i = 0; i < 4; i++) occ = occ + {2'b00, bv_q[i]};
    for (int i = 0; i <= RD_LAT; i++) inflight = inflight + {2'b00, tag_v_q[i]};
    pop = bv_q[0] & m_tready;

    case (state_q)
      S_IDLE: begin
        rd_ptr_d = wr_ptr;
        if (enable) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (fill_q > OVR_TH) begin
          rd_ptr_d = wr_ptr;
          ovr_ev   = 1'b1;
        end else if (!enable) begin
          state_d = S_IDLE;
        end else if (fill_q >= FRAME15) begin
          cnt_d   = FRAME15;
          state_d = S_READ;
        end
      end
      S_READ: begin
        // Buffered plus in-flight reads never exceed the four buffer slots.
        if (({1'b0, occ} + {1'b0, inflight}) < 4'd4) begin
          issue      = 1'b1;
          ram_addr_d = rd_ptr_q;
          rd_ptr_d   = (rd_ptr_q == LAST_ADDR) ? 14'd0 : rd_ptr_q + 14'd1;
          cnt_d      = cnt_q - 15'd1;
          if (cnt_q == 15'd1) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (pop && bl_q[0]) begin
          frame_done_d = 1'b1;
          state_d      = S_WAIT;
        end
      end
      default: state_d = S_IDLE;
    endcase

    last_issue = issue && (cnt_q == 15'd1);
    tag_v_d    = {tag_v_q[RD_LAT-1:0], issue};
    tag_l_d    = {tag_l_q[RD_LAT-1:0], last_issue};
    capture    = tag_v_q[RD_LAT];

    bv_d = bv_q;
    bl_d = bl_q;
    bd_d = bd_q;
    if (pop) begin
      for (int i = 0; i < 3; i++) begin
        bv_d[i] = bv_q[i+1];
        bl_d[i] = bl_q[i+1];
        bd_d[i] = bd_q[i+1];
      end
      bv_d[3] = 1'b0;
      bl_d[3] = 1'b0;
      bd_d[3] = 32'd0;
    end
    widx = occ - {2'b00, pop};
    for (int i = 0; i < 4; i++) begin
      if (capture && widx == 3'(i)) begin
        bv_d[i] = 1'b1;
        bl_d[i] = tag_l_q[RD_LAT];
        bd_d[i] = ram_rdata;
      end
    end

    ovr_flag_d = ovr_ev ? 1'b1 : (ovr_clr ? 1'b0 : ovr_flag_q);

    // Fill tracks the next read pointer so a resync is never seen twice as an overrun.
    fill_d = (wr_ptr >= rd_ptr_d) ? ({1'b0, wr_ptr} - {1'b0, rd_ptr_d})
                                  : ({1'b0, wr_ptr} + DEPTH15 - {1'b0, rd_ptr_d});

`ifdef DDC_RD_STAT_EN
    frame_cnt_d = ovr_clr ? 16'd0 : frame_cnt_q;
    if (frame_done_d) frame_cnt_d = frame_cnt_d + 16'd1;
    ovr_cnt_d = ovr_clr ? 8'd0 : ovr_cnt_q;
    if (ovr_ev && ovr_cnt_d != 8'hFF) ovr_cnt_d = ovr_cnt_d + 8'd1;
`endif
  end

  always_ff @(posedge lbs_clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      rd_ptr_q     <= 14'd0;
      fill_q       <= 15'd0;
      cnt_q        <= 15'd0;
      ram_addr_q   <= 14'd0;
      tag_v_q      <= '0;
      tag_l_q      <= '0;
      bv_q         <= 4'd0;
      bl_q         <= 4'd0;
      for (int i = 0; i < 4; i++) bd_q[i] <= 32'd0;
      frame_done_q <= 1'b0;
      ovr_flag_q   <= 1'b0;
      busy_q       <= 1'b0;
`ifdef DDC_RD_STAT_EN
      frame_cnt_q  <= 16'd0;
      ovr_cnt_q    <= 8'd0;
`endif
    end else begin
      state_q      <= state_d;
      rd_ptr_q     <= rd_ptr_d;
      fill_q       <= fill_d;
      cnt_q        <= cnt_d;
      ram_addr_q   <= ram_addr_d;
      tag_v_q      <= tag_v_d;
      tag_l_q      <= tag_l_d;
      bv_q         <= bv_d;
      bl_q         <= bl_d;
      for (int i = 0; i < 4; i++) bd_q[i] <= bd_d[i];
      frame_done_q <= frame_done_d;
      ovr_flag_q   <= ovr_flag_d;
      busy_q       <= (state_d != S_IDLE);
`ifdef DDC_RD_STAT_EN
      frame_cnt_q  <= frame_cnt_d;
      ovr_cnt_q    <= ovr_cnt_d;
`endif
    end
  end

  assign ram_addr   = ram_addr_q;
  assign m_tvalid   = bv_q[0];
  assign m_tdata    = bd_q[0];
  assign m_tlast    = bl_q[0];
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign ovr_flag   = ovr_flag_q;
  assign dbg_state  = state_q;
`ifdef DDC_RD_STAT_EN
  assign frame_cnt  = frame_cnt_q;
  assign ovr_cnt    = ovr_cnt_q;
`endif

endmodule

// File: tb/tb_ddc_buf_rd_sched.sv
// Bench for ddc_buf_rd_sched: RD_LAT=1 instance for frame/wrap/overrun/enable/reset cases,
// RD_LAT=3 instance under random backpressure. RAM content is a fixed function of address.
module tb_ddc_buf_rd_sched;

  localparam int DEPTH = 11521;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance A (RD_LAT=1)
  logic        a_enable, a_tready, a_ovr_clr;
  logic [13:0] a_wr_ptr, a_ram_addr;
  logic [31:0] a_rdata, a_tdata;
  logic        a_tvalid, a_tlast, a_busy, a_frame_done, a_ovr_flag;
  logic [1:0]  a_dbg_state;
  // Instance B (RD_LAT=3)
  logic        b_enable, b_tready, b_ovr_clr;
  logic [13:0] b_wr_ptr, b_ram_addr;
  logic [31:0] b_rdata, b_tdata, b_p1, b_p2;
  logic        b_tvalid, b_tlast, b_busy, b_frame_done, b_ovr_flag;
  logic [1:0]  b_dbg_state;
`ifdef DDC_RD_STAT_EN
  logic [15:0] a_frame_cnt, b_frame_cnt;
  logic [7:0]  a_ovr_cnt, b_ovr_cnt;
`endif

  ddc_buf_rd_sched #(.RD_LAT(1)) u_dut_a (
    .lbs_clk(clk), .rst(rst), .enable(a_enable), .wr_ptr(a_wr_ptr), .ram_addr(a_ram_addr),
    .ram_rdata(a_rdata), .m_tvalid(a_tvalid), .m_tready(a_tready), .m_tdata(a_tdata),
    .m_tlast(a_tlast), .busy(a_busy), .frame_done(a_frame_done), .ovr_flag(a_ovr_flag),
    .ovr_clr(a_ovr_clr), .dbg_state(a_dbg_state)
`ifdef DDC_RD_STAT_EN
    , .frame_cnt(a_frame_cnt), .ovr_cnt(a_ovr_cnt)
`endif
  );

  ddc_buf_rd_sched #(.RD_LAT(3)) u_dut_b (
    .lbs_clk(clk), .rst(rst), .enable(b_enable), .wr_ptr(b_wr_ptr), .ram_addr(b_ram_addr),
    .ram_rdata(b_rdata), .m_tvalid(b_tvalid), .m_tready(b_tready), .m_tdata(b_tdata),
    .m_tlast(b_tlast), .busy(b_busy), .frame_done(b_frame_done), .ovr_flag(b_ovr_flag),
    .ovr_clr(b_ovr_clr), .dbg_state(b_dbg_state)
`ifdef DDC_RD_STAT_EN
    , .frame_cnt(b_frame_cnt), .ovr_cnt(b_ovr_cnt)
`endif
  );

  function automatic logic [31:0] data_fn(input logic [13:0] a);
    logic [15:0] x;
    x = {2'b00, a};
    return {x ^ 16'hA5A5, x * 16'd3 + 16'h0101};
  endfunction

  function automatic logic [13:0] next_addr(input logic [13:0] a);
    return (a == 14'(DEPTH - 1)) ? 14'd0 : a + 14'd1;
  endfunction

  // RAM models: data appears RD_LAT cycles after the address
  always @(posedge clk) begin
    a_rdata <= data_fn(a_ram_addr);
    b_p1    <= data_fn(b_ram_addr);
    b_p2    <= b_p1;
    b_rdata <= b_p2;
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboards: {last, data}
  logic [32:0] a_exp_q[$];
  logic [32:0] b_exp_q[$];
  logic [32:0] a_e, b_e;
  int cyc = 0;
  int a_fd_cnt = 0, b_fd_cnt = 0, a_beats = 0;
  int a_first_cyc = 0, a_last_cyc = 0;
  logic        b_rand = 1'b0;
  logic        b_hold = 1'b0, b_hold_last = 1'b0;
  logic [31:0] b_hold_data = 32'd0;

  always @(posedge clk) begin
    #1;
    b_tready = b_rand ? ($urandom_range(0, 99) < 30) : 1'b1;
  end

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (!rst) begin
      if (a_frame_done) a_fd_cnt++;
      if (b_frame_done) b_fd_cnt++;
      if (a_tvalid && a_tready) begin
        if (a_beats == 0) a_first_cyc = cyc;
        a_beats++;
        if (a_exp_q.size() == 0) check("a_unexpected_beat", {31'd0, a_tvalid}, 32'd0);
        else begin
          a_e = a_exp_q.pop_front();
          check("a_tdata", a_tdata, a_e[31:0]);
          check("a_tlast", {31'd0, a_tlast}, {31'd0, a_e[32]});
          if (a_e[32]) a_last_cyc = cyc;
        end
      end
      if (b_hold) begin
        check("b_stable_valid", {31'd0, b_tvalid}, 32'd1);
        check("b_stable_data", b_tdata, b_hold_data);
        check("b_stable_last", {31'd0, b_tlast}, {31'd0, b_hold_last});
      end
      b_hold      = b_tvalid && !b_tready;
      b_hold_data = b_tdata;
      b_hold_last = b_tlast;
      if (b_tvalid && b_tready) begin
        if (b_exp_q.size() == 0) check("b_unexpected_beat", {31'd0, b_tvalid}, 32'd0);
        else begin
          b_e = b_exp_q.pop_front();
          check("b_tdata", b_tdata, b_e[31:0]);
          check("b_tlast", {31'd0, b_tlast}, {31'd0, b_e[32]});
        end
      end
    end else begin
      b_hold = 1'b0;
    end
  end

  task automatic push_a(input logic [13:0] first, input int n);
    logic [13:0] a;
    a = first;
    for (int i = 0; i < n; i++) begin
      a_exp_q.push_back({(i == n - 1), data_fn(a)});
      a = next_addr(a);
    end
  endtask

  task automatic wait_a_fd(input int target, input string nm);
    int n;
    n = 0;
    while (a_fd_cnt < target && n < 3000) begin
      tick(1);
      n++;
    end
    check({nm, "_fd_timeout"}, {31'd0, a_fd_cnt >= target}, 32'd1);
  endtask

  task automatic wait_a_beats(input int target, input string nm);
    int n;
    n = 0;
    while (a_beats < target && n < 2000) begin
      tick(1);
      n++;
    end
    check({nm, "_beat_timeout"}, {31'd0, a_beats >= target}, 32'd1);
  endtask

  task automatic run_frame(input string nm, input logic [13:0] p0, input logic [13:0] w1,
                           input logic [13:0] first, input logic [13:0] last_a);
    int fd0;
    a_enable = 1'b0;
    a_wr_ptr = p0;
    tick(3);
    @(negedge clk);
    check({nm, "_idle_state"}, {30'd0, a_dbg_state}, {30'd0, ST_IDLE});
    check({nm, "_idle_busy"}, {31'd0, a_busy}, 32'd0);
    a_enable = 1'b1;
    tick(2);
    @(negedge clk);
    check({nm, "_wait_state"}, {30'd0, a_dbg_state}, {30'd0, ST_WAIT});
    push_a(first, 256);
    fd0 = a_fd_cnt;
    a_beats = 0;
    tick(1);
    a_wr_ptr = w1;
    wait_a_fd(fd0 + 1, nm);
    tick(3);
    @(negedge clk);
    check({nm, "_fd_count"}, a_fd_cnt, fd0 + 1);
    check({nm, "_pending"}, a_exp_q.size(), 32'd0);
    check({nm, "_last_addr"}, {18'd0, a_ram_addr}, {18'd0, last_a});
    check({nm, "_after_state"}, {30'd0, a_dbg_state}, {30'd0, ST_WAIT});
    check({nm, "_after_valid"}, {31'd0, a_tvalid}, 32'd0);
    check({nm, "_throughput"}, a_last_cyc - a_first_cyc, 32'd255);
  endtask

  typedef struct {
    logic [13:0] p0;
    logic [13:0] w1;
    logic [13:0] first;
    logic [13:0] last_a;
  } vec_t;
  vec_t vecs[3];

  initial begin
    int fd0, n;
    vecs[0] = '{14'd0, 14'd300, 14'd0, 14'd255};          // basic frame, fill 300
    vecs[1] = '{14'd11400, 14'd135, 14'd11400, 14'd134};  // straddles the wrap
    vecs[2] = '{14'd5000, 14'd5256, 14'd5000, 14'd5255};  // exact fill 256

    rst = 1'b1;
    a_enable = 1'b0; a_wr_ptr = 14'd0; a_ovr_clr = 1'b0; a_tready = 1'b1;
    b_enable = 1'b0; b_wr_ptr = 14'd0; b_ovr_clr = 1'b0;
    tick(3);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ram_addr", {18'd0, a_ram_addr}, 32'd0);
    check("rst_tvalid", {31'd0, a_tvalid}, 32'd0);
    check("rst_tdata", a_tdata, 32'd0);
    check("rst_tlast", {31'd0, a_tlast}, 32'd0);
    check("rst_busy", {31'd0, a_busy}, 32'd0);
    check("rst_frame_done", {31'd0, a_frame_done}, 32'd0);
    check("rst_ovr_flag", {31'd0, a_ovr_flag}, 32'd0);
    check("rst_state", {30'd0, a_dbg_state}, {30'd0, ST_IDLE});
    check("rst_b_tvalid", {31'd0, b_tvalid}, 32'd0);

    for (int i = 0; i < 3; i++)
      run_frame($sformatf("row%0d", i), vecs[i].p0, vecs[i].w1, vecs[i].first, vecs[i].last_a);
`ifdef DDC_RD_STAT_EN
    check("stat_frame_cnt", {16'd0, a_frame_cnt}, 32'd3);
`endif

    // Enable dropped at beat 100: frame still completes, then IDLE
    push_a(14'd5256, 256);
    fd0 = a_fd_cnt;
    a_beats = 0;
    a_wr_ptr = 14'd5512;
    wait_a_beats(100, "en_drop");
    a_enable = 1'b0;
    wait_a_fd(fd0 + 1, "en_drop");
    @(negedge clk);
    check("en_drop_busy", {31'd0, a_busy}, 32'd0);
    check("en_drop_state", {30'd0, a_dbg_state}, {30'd0, ST_IDLE});
    check("en_drop_pending", a_exp_q.size(), 32'd0);

    // Overrun: fill 11460 while waiting
    a_enable = 1'b1;
    tick(2);
    a_wr_ptr = 14'd5451;
    tick(2);
    @(negedge clk);
    check("ovr_flag_set", {31'd0, a_ovr_flag}, 32'd1);
    check("ovr_state", {30'd0, a_dbg_state}, {30'd0, ST_WAIT});
    a_ovr_clr = 1'b1;
    tick(1);
    a_ovr_clr = 1'b0;
    @(negedge clk);
    check("ovr_flag_clr", {31'd0, a_ovr_flag}, 32'd0);
    // Resynchronised read pointer: next frame starts at the writer position
    push_a(14'd5451, 256);
    fd0 = a_fd_cnt;
    a_wr_ptr = 14'd5707;
    wait_a_fd(fd0 + 1, "ovr_resync");
    tick(2);
    @(negedge clk);
    check("ovr_resync_pending", a_exp_q.size(), 32'd0);
    check("ovr_flag_quiet", {31'd0, a_ovr_flag}, 32'd0);
    // Clear coinciding with a new overrun: set wins
    a_wr_ptr = 14'd5646;
    tick(1);
    a_ovr_clr = 1'b1;
    tick(1);
    a_ovr_clr = 1'b0;
    @(negedge clk);
    check("ovr_set_wins", {31'd0, a_ovr_flag}, 32'd1);

    // Reset at beat 50
    push_a(14'd5646, 256);
    a_beats = 0;
    a_wr_ptr = 14'd5902;
    wait_a_beats(50, "rst_mid");
    rst = 1'b1;
    #1;
    check("rst_mid_tvalid", {31'd0, a_tvalid}, 32'd0);
    check("rst_mid_busy", {31'd0, a_busy}, 32'd0);
    check("rst_mid_ram_addr", {18'd0, a_ram_addr}, 32'd0);
    check("rst_mid_ovr_flag", {31'd0, a_ovr_flag}, 32'd0);
    check("rst_mid_state", {30'd0, a_dbg_state}, {30'd0, ST_IDLE});
`ifdef DDC_RD_STAT_EN
    check("rst_mid_frame_cnt", {16'd0, a_frame_cnt}, 32'd0);
`endif
    a_exp_q.delete();
    tick(2);
    rst = 1'b0;
    run_frame("post_rst", 14'd100, 14'd356, 14'd100, 14'd355);

    // Instance B: two back-to-back frames across the wrap under 30% tready
    b_wr_ptr = 14'd11450;
    tick(3);
    b_enable = 1'b1;
    tick(2);
    for (int i = 0; i < 512; i++)
      b_exp_q.push_back({(i == 255 || i == 511), data_fn(14'((11450 + i) % DEPTH))});
    fd0 = b_fd_cnt;
    b_rand = 1'b1;
    b_wr_ptr = 14'd441;
    n = 0;
    while (b_fd_cnt < fd0 + 2 && n < 8000) begin
      tick(1);
      n++;
    end
    check("b_fd_timeout", {31'd0, b_fd_cnt >= fd0 + 2}, 32'd1);
    b_rand = 1'b0;
    tick(3);
    @(negedge clk);
    check("b_fd_count", b_fd_cnt, fd0 + 2);
    check("b_pending", b_exp_q.size(), 32'd0);
    check("b_last_addr", {18'd0, b_ram_addr}, 32'd440);
    check("b_state", {30'd0, b_dbg_state}, {30'd0, ST_WAIT});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
